// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Grants one requester per cycle and registers the winning write for the next cycle.
module regfile_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        WriteRegister,
    output logic [DATA_W-1:0]        WriteData,
    output logic                     busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(31);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0]     ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic [PW-1:0]     win;
    logic              found;
    int                idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Scan from ptr upward, wrapping; the first active request wins.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (reset && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(ptr_q) + k) % NREQ;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    win      = PW'(idx);
                    gnt[idx] = 1'b1;
                end
            end
        end
    end

    assign win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
    assign win_data = req_data[int'(win)*DATA_W +: DATA_W];

    always_comb begin
        ptr_d = ptr_q;
        rw_d  = 1'b0;
        wa_d  = wa_q;
        wd_d  = wd_q;
        if (found) begin
            wa_d  = win_addr;
            wd_d  = win_data;
            // XZR writes are consumed but never enable the register file.
            rw_d  = (win_addr != XZR);
            ptr_d = (win == LAST) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            rw_q  <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            rw_q  <= rw_d;
            wa_q  <= wa_d;
            wd_q  <= wd_d;
        end
    end

    assign RegWrite      = rw_q;
    assign WriteRegister = wa_q;
    assign WriteData     = wd_q;
    assign busy          = rw_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter.
// Expected values come from a queue-free behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
    localparam int AW = 5;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0] gnt;
    logic RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic busy;

    int errors = 0;
    int checks = 0;

    int m_ptr = 0;
    logic m_rw = 1'b0;
    logic [AW-1:0] m_wa = '0;
    logic [DW-1:0] m_wd = '0;

    regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk),
        .reset(rst_n),
        .hold(hold),
        .req(req),
        .req_addr(req_addr),
        .req_data(req_data),
        .gnt(gnt),
        .RegWrite(RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NREQ-1:0] exp_gnt();
        logic [NREQ-1:0] g;
        int i;
        g = '0;
        if (rst_n && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (g == 0 && req[i]) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_rw = 1'b0;
        m_wa = '0;
        m_wd = '0;
    endtask

    // Advance one rising edge and apply the transfer rules to the model.
    task automatic cyc();
        logic [NREQ-1:0] g;
        logic [AW-1:0] a;
        g = exp_gnt();
        @(posedge clk);
        if (rst_n) begin
            m_rw = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    a = req_addr[i*AW +: AW];
                    m_wa = a;
                    m_wd = req_data[i*DW +: DW];
                    m_rw = (a != 5'd31);
                    m_ptr = (i + 1) % NREQ;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        hold = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(i + 100));
        #2;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt: got %b want 0000", gnt);
        end
        checks++;
        if ({RegWrite, busy, WriteRegister, WriteData} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got rw=%b busy=%b wa=%0d wd=%h want 0",
                     RegWrite, busy, WriteRegister, WriteData);
        end
        cyc();
        cyc();
        checks++;
        if (RegWrite !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held: got rw=%b gnt=%b want 0/0000",
                     RegWrite, gnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_gnt: got %b want 0001", gnt);
        end
        cyc();
        req = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 5'd5, 64'hDEAD_BEEF_0000_0001);
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL single_gnt: got %b want 0100", gnt);
        end
        cyc();
        req = '0;
        checks++;
        if (RegWrite !== 1'b1 || busy !== 1'b1 || WriteRegister !== 5'd5 ||
            WriteData !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL single_write: got rw=%b busy=%b wa=%0d wd=%h want 1/1/5/deadbeef00000001",
                     RegWrite, busy, WriteRegister, WriteData);
        end
        cyc();
        checks++;
        if (RegWrite !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got rw=%b busy=%b want 0", RegWrite, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 8), DW'(64'h1000 + i));
        for (int k = 0; k < 8; k++) begin
            #1;
            want = 4'b0001 << (k % 4);
            checks++;
            if (gnt !== want) begin
                errors++;
                $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, want);
            end
            cyc();
            checks++;
            if (RegWrite !== 1'b1 || WriteRegister !== AW'((k % 4) + 8) ||
                WriteData !== DW'(64'h1000 + (k % 4))) begin
                errors++;
                $display("FAIL rr_write[%0d]: got rw=%b wa=%0d wd=%h want 1/%0d",
                         k, RegWrite, WriteRegister, WriteData, (k % 4) + 8);
            end
        end
        req = '0;
    endtask

    task automatic test_wrap_skip();
        do_reset();
        set_req(2, 5'd3, 64'h22);
        cyc();
        req = '0;
        set_req(0, 5'd1, 64'h11);
        set_req(1, 5'd2, 64'h12);
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_gnt0: got %b want 0001", gnt);
        end
        cyc();
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_gnt1: got %b want 0010", gnt);
        end
        cyc();
        req = '0;
    endtask

    task automatic test_xzr();
        do_reset();
        set_req(0, 5'd31, 64'hFFFF);
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL xzr_gnt: got %b want 0001", gnt);
        end
        cyc();
        checks++;
        if (RegWrite !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL xzr_rw: got rw=%b busy=%b want 0", RegWrite, busy);
        end
        set_req(1, 5'd4, 64'h44);
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL xzr_ptr: got %b want 0010", gnt);
        end
        cyc();
        req = '0;
    endtask

    task automatic test_hold_reset();
        do_reset();
        hold = 1'b1;
        set_req(1, 5'd9, 64'h99);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000 || RegWrite !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got gnt=%b rw=%b want 0000/0", k, gnt, RegWrite);
            end
            cyc();
        end
        hold = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL hold_release: got %b want 0010", gnt);
        end
        cyc();
        req = '0;
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd9) begin
            errors++;
            $display("FAIL hold_write: got rw=%b wa=%0d want 1/9", RegWrite, WriteRegister);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (RegWrite !== 1'b0 || busy !== 1'b0 || WriteRegister !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: got rw=%b busy=%b wa=%0d want 0/0/0",
                     RegWrite, busy, WriteRegister);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] want;
        int fails = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            hold = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) != 0)
                    set_req(i, ($urandom_range(0, 7) == 0) ? 5'd31 : AW'($urandom_range(0, 31)),
                            {$urandom, $urandom});
            end
            #1;
            want = exp_gnt();
            checks++;
            if (gnt !== want) begin
                errors++;
                if (fails++ < 10)
                    $display("FAIL rand_gnt[%0d]: got %b want %b", c, gnt, want);
            end
            g = want;
            cyc();
            checks++;
            if (RegWrite !== m_rw || busy !== m_rw || WriteRegister !== m_wa ||
                WriteData !== m_wd) begin
                errors++;
                if (fails++ < 10)
                    $display("FAIL rand_out[%0d]: got rw=%b wa=%0d wd=%h want rw=%b wa=%0d wd=%h",
                             c, RegWrite, WriteRegister, WriteData, m_rw, m_wa, m_wd);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, AW'($urandom_range(0, 31)), {$urandom, $urandom});
                    else
                        req[i] = 1'b0;
                end
            end
        end
        req = '0;
        hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_xzr();
        test_hold_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
